// File: rtl/controlador_sequencia.sv
// Moore control unit for the sequence-memory datapath: clears and steps the address
// counter, loads the input register and decides success, mismatch or inactivity timeout.
module controlador_sequencia #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_contagem,
    output logic       zera_end_n,
    output logic       conta_end,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] estado
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARACAO  = 4'd1,
        ESPERA      = 4'd2,
        REGISTRA    = 4'd3,
        COMPARACAO  = 4'd4,
        PROXIMO     = 4'd5,
        FIM_ACERTO  = 4'd6,
        FIM_ERRO    = 4'd7,
        FIM_TIMEOUT = 4'd8
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          zera_end_n_q, conta_end_q, registra_q;
    logic          pronto_q, acertou_q, errou_q, timeout_q;

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL:     if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:  estado_d = ESPERA;
            // A move arriving on the last allowed cycle still counts.
            ESPERA: begin
                if (jogada)                     estado_d = REGISTRA;
                else if (timer_q == TIMER_LAST) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:    estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)            estado_d = FIM_ERRO;
                else if (fim_contagem) estado_d = FIM_ACERTO;
                else                   estado_d = PROXIMO;
            end
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
            default:     estado_d = INICIAL;
        endcase
    end

    // The timer only runs while in espera and restarts from zero on every entry.
    always_comb begin
        timer_d = '0;
        if (estado_d == ESPERA && estado_q == ESPERA) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Outputs are decoded from the next state so they are registered yet still track
    // the state register cycle for cycle.
    always_ff @(posedge clock) begin
        if (!clr) begin
            estado_q     <= INICIAL;
            timer_q      <= '0;
            zera_end_n_q <= 1'b0;
            conta_end_q  <= 1'b0;
            registra_q   <= 1'b0;
            pronto_q     <= 1'b0;
            acertou_q    <= 1'b0;
            errou_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            timer_q      <= timer_d;
            zera_end_n_q <= !(estado_d == INICIAL || estado_d == PREPARACAO);
            conta_end_q  <= (estado_d == PROXIMO);
            registra_q   <= (estado_d == REGISTRA);
            pronto_q     <= (estado_d == FIM_ACERTO || estado_d == FIM_ERRO ||
                             estado_d == FIM_TIMEOUT);
            acertou_q    <= (estado_d == FIM_ACERTO);
            errou_q      <= (estado_d == FIM_ERRO);
            timeout_q    <= (estado_d == FIM_TIMEOUT);
        end
    end

    assign zera_end_n = zera_end_n_q;
    assign conta_end  = conta_end_q;
    assign registra   = registra_q;
    assign pronto     = pronto_q;
    assign acertou    = acertou_q;
    assign errou      = errou_q;
    assign timeout    = timeout_q;
    assign estado     = estado_q;

endmodule

// File: tb/tb_controlador_sequencia.sv
// Scoreboard bench for controlador_sequencia: directed moves push expected state/outputs,
// a negedge monitor pops and compares them, plus counts of address-counter pulses.
module tb_controlador_sequencia;

    logic       clock = 1'b0;
    logic       clr, iniciar, jogada, igual, fim_contagem;
    logic       zera_end_n, conta_end, registra, pronto, acertou, errou, timeout;
    logic [3:0] estado;

    controlador_sequencia #(.TIMEOUT(8)) dut (
        .clock(clock), .clr(clr), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fim_contagem(fim_contagem), .zera_end_n(zera_end_n),
        .conta_end(conta_end), .registra(registra), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout), .estado(estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: kind 0 = output snapshot, kind 1 = conta_end pulse count since base.
    int          q_cyc[$];
    int          q_kind[$];
    logic [31:0] q_exp[$];
    int          q_base[$];
    string       q_nm[$];

    int   compared  = 0;
    int   failed    = 0;
    int   conta_cnt = 0;
    logic done      = 1'b0;

    // Expected output vector for a state code, straight from the state table.
    function automatic logic [31:0] exp_of(input logic [3:0] s);
        logic z, c, r, p, a, e, t;
        z = !(s == 4'd0 || s == 4'd1);
        c = (s == 4'd5);
        r = (s == 4'd3);
        p = (s == 4'd6 || s == 4'd7 || s == 4'd8);
        a = (s == 4'd6);
        e = (s == 4'd7);
        t = (s == 4'd8);
        return {21'd0, z, c, r, p, a, e, t, s};
    endfunction

    always @(negedge clock) begin
        logic [31:0] act;
        logic [31:0] got;
        if (conta_end === 1'b1) conta_cnt = conta_cnt + 1;
        act = {21'd0, zera_end_n, conta_end, registra, pronto, acertou, errou, timeout, estado};
        while (q_cyc.size() > 0 && (q_cyc[0] <= cyc || done)) begin
            compared = compared + 1;
            got = (q_kind[0] == 0) ? act : 32'(conta_cnt - q_base[0]);
            if (q_cyc[0] != cyc || got !== q_exp[0]) begin
                failed = failed + 1;
                $display("FAIL %s: cycle %0d got %h required %h (due cycle %0d)",
                         q_nm[0], cyc, got, q_exp[0], q_cyc[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_kind.pop_front());
            void'(q_exp.pop_front());
            void'(q_base.pop_front());
            void'(q_nm.pop_front());
        end
    end

    task automatic check_now(input logic [3:0] s, input string nm);
        logic [31:0] act;
        act = {21'd0, zera_end_n, conta_end, registra, pronto, acertou, errou, timeout, estado};
        compared = compared + 1;
        if (act !== exp_of(s)) begin
            failed = failed + 1;
            $display("FAIL %s (immediate): cycle %0d got %h required %h",
                     nm, cyc, act, exp_of(s));
        end
    endtask

    // Drive one cycle of inputs; expect state s after the next rising edge.
    task automatic step(input logic c, input logic i, input logic j, input logic g,
                        input logic f, input logic [3:0] s, input string nm);
        clr = c; iniciar = i; jogada = j; igual = g; fim_contagem = f;
        q_cyc.push_back(cyc + 1);
        q_kind.push_back(0);
        q_exp.push_back(exp_of(s));
        q_base.push_back(0);
        q_nm.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pulses(input int base, input int n, input string nm);
        q_cyc.push_back(cyc);
        q_kind.push_back(1);
        q_exp.push_back(32'(n));
        q_base.push_back(base);
        q_nm.push_back(nm);
    endtask

    task automatic move_ok(input string nm);
        step(1, 0, 1, 0, 0, 4'd3, {nm, "_reg"});
        step(1, 0, 0, 0, 0, 4'd4, {nm, "_cmp"});
        step(1, 0, 0, 1, 0, 4'd5, {nm, "_prox"});
        step(1, 0, 0, 0, 0, 4'd2, {nm, "_esp"});
    endtask

    initial begin
        int base;
        clr = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim_contagem = 1'b0;
        @(posedge clock);
        #1;
        step(0, 1, 1, 1, 1, 4'd0, "reset0");
        step(0, 0, 0, 0, 0, 4'd0, "reset1");
        check_now(4'd0, "reset_state");
        step(1, 0, 1, 0, 0, 4'd0, "idle_no_start");

        // Full success over four words, with ignored inputs sprinkled in.
        step(1, 1, 0, 0, 0, 4'd1, "a_start");
        step(1, 0, 0, 0, 0, 4'd2, "a_prep");
        base = conta_cnt;
        move_ok("a_m1");
        step(1, 0, 1, 0, 0, 4'd3, "a_m2_reg");
        step(1, 0, 1, 0, 0, 4'd4, "a_m2_jog_in_reg");
        step(1, 0, 0, 1, 0, 4'd5, "a_m2_prox");
        step(1, 0, 1, 0, 0, 4'd2, "a_m2_jog_in_prox");
        step(1, 1, 0, 0, 0, 4'd2, "a_ini_in_espera");
        move_ok("a_m3");
        step(1, 0, 1, 0, 0, 4'd3, "a_m4_reg");
        step(1, 0, 0, 0, 0, 4'd4, "a_m4_cmp");
        step(1, 0, 0, 1, 1, 4'd6, "a_acerto");
        step(1, 0, 1, 0, 0, 4'd6, "a_hold");
        expect_pulses(base, 3, "a_conta_pulses");

        // Mismatch on the second move.
        step(1, 1, 0, 0, 0, 4'd1, "b_start");
        step(1, 0, 0, 0, 0, 4'd2, "b_prep");
        base = conta_cnt;
        move_ok("b_m1");
        step(1, 0, 1, 0, 0, 4'd3, "b_m2_reg");
        step(1, 0, 0, 0, 0, 4'd4, "b_m2_cmp");
        step(1, 0, 0, 0, 1, 4'd7, "b_erro");
        step(1, 0, 0, 1, 0, 4'd7, "b_hold");
        expect_pulses(base, 1, "b_conta_pulses");

        // Restart from fim_erro, then let espera run out.
        step(1, 1, 0, 0, 0, 4'd1, "c_restart");
        step(1, 0, 0, 0, 0, 4'd2, "c_esp_entry");
        for (int k = 1; k < 8; k++) step(1, 0, 0, 0, 0, 4'd2, "c_esp_wait");
        step(1, 0, 0, 0, 0, 4'd8, "c_timeout");
        check_now(4'd8, "expired_wait");
        step(1, 0, 0, 0, 0, 4'd8, "c_hold");

        // Move on the last allowed cycle beats the timeout; then reset mid-compare.
        step(1, 1, 0, 0, 0, 4'd1, "d_start");
        step(1, 0, 0, 0, 0, 4'd2, "d_esp_entry");
        for (int k = 1; k < 8; k++) step(1, 0, 0, 0, 0, 4'd2, "d_esp_wait");
        step(1, 0, 1, 0, 0, 4'd3, "d_last_cycle_move");
        step(1, 0, 0, 0, 0, 4'd4, "d_cmp");
        step(0, 1, 1, 1, 1, 4'd0, "d_reset_mid");
        check_now(4'd0, "reset_mid_round");
        step(1, 0, 0, 0, 0, 4'd0, "d_after_reset");

        for (int k = 0; k < 4 && q_cyc.size() > 0; k++) @(negedge clock);
        done = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/controlador_sequencia.md
# controlador_sequencia

Moore controller that sequences the 4-bit address counter, input register and comparator of the sequence-memory datapath. It steps the counter through the stored sequence one player move at a time, checks each move, and ends the round on full success, first mismatch, or inactivity timeout. It sits between the top-level game logic (start/move pulses, result LEDs) and the datapath.

## Interface
- TIMEOUT, 1000: maximum cycles spent waiting for one move; legal range 2..65535.
- clock  in  1  system clock; all state changes on rising edge.
- clr  in  1  synchronous, active-low reset; highest priority.
- iniciar  in  1  start request; level sampled each cycle.
- jogada  in  1  one-cycle pulse, player move available (already debounced/edge-detected).
- igual  in  1  comparator result, memory word at current address == input register.
- fim_contagem  in  1  address counter carry (counter at last sequence address).
- zera_end_n  out  1  active-low synchronous clear to address counter.
- conta_end  out  1  count enable to address counter (drive both ent and enp).
- registra  out  1  load enable for the input register.
- pronto  out  1  round finished.
- acertou  out  1  round ended by full success.
- errou  out  1  round ended by mismatch.
- timeout  out  1  round ended by inactivity.
- estado  out  4  current state code, for debug display.

## Operation
- States/codes: inicial 0, preparacao 1, espera 2, registra 3, comparacao 4, proximo 5, fim_acerto 6, fim_erro 7, fim_timeout 8. Codes 9..15 unused; if reached, next state = inicial.
- All outputs are pure Moore decode of the state register; no output depends on inputs.
- inicial: zera_end_n=0; iniciar=1 -> preparacao, else stay.
- preparacao: zera_end_n=0; timer cleared -> espera (unconditional).
- espera: timer increments each cycle. jogada=1 -> registra (jogada wins over timeout in same cycle); else timer==TIMEOUT-1 -> fim_timeout; else stay.
- registra: registra=1 -> comparacao.
- comparacao: igual=0 -> fim_erro; igual=1 and fim_contagem=1 -> fim_acerto; igual=1 and fim_contagem=0 -> proximo.
- proximo: conta_end=1; timer cleared -> espera.
- fim_acerto/fim_erro/fim_timeout: pronto=1 plus acertou/errou/timeout respectively; hold until iniciar=1 -> preparacao (new round, counter cleared again).
- Internal timer: unsigned, width $clog2(TIMEOUT); forced to 0 whenever state is not espera; no wrap possible because espera exits at TIMEOUT-1.
- jogada outside espera is ignored (not queued). iniciar outside inicial/final states is ignored.
- Exactly one of acertou/errou/timeout is high when pronto=1; all three low when pronto=0.

## Timing
- clr=0 at any edge: next state inicial, timer 0, regardless of other inputs, including mid-round.
- Reset/inicial output values: zera_end_n=0, conta_end=0, registra=0, pronto=0, acertou=0, errou=0, timeout=0, estado=0.
- iniciar high at edge t (in inicial): preparacao during t+1, espera from t+2; counter reads 0 from t+2.
- Per move, jogada at edge t in espera: registra t+1, comparacao t+2 (igual must be valid this cycle, input register loaded at end of t+1), proximo t+3, espera t+4 with counter already incremented.
- Timeout: espera entered at cycle e, no jogada -> fim_timeout at e+TIMEOUT.
- Result flags asserted the cycle after the deciding edge, held stable until leaving the final state.

## Test plan
- Reset mid-round: drive clr=0 for one cycle while in comparacao -> next cycle estado=0, zera_end_n=0, all flags 0.
- Full success, 4-word sequence (fim_contagem high on 4th compare), igual=1 every move -> conta_end pulses exactly 3 times, then estado=6, pronto=1, acertou=1.
- Mismatch on 2nd move (igual=0) -> estado=7, errou=1, exactly one conta_end pulse seen, acertou=0.
- TIMEOUT=8, start, no jogada -> fim_timeout exactly 8 cycles after espera entry, estado=8, timeout=1; jogada pulsing on cycle 8 of espera instead -> registra, no timeout.
- Ignored inputs: jogada pulses during registra/proximo and iniciar during espera -> no state change beyond normal sequence.
- Restart: from fim_erro assert iniciar -> preparacao next cycle, flags cleared, zera_end_n=0 for that cycle.
